// File: rtl/counter_ud_ctrl_if.sv
// ----------------------------------------------------------------------------
// counter_ud_ctrl_if
// Command/feedback bus between the sweep sequencer and the up/down counter.
//   load_en     : sequencer -> counter, load the counter from 'load'
//   load        : sequencer -> counter, value to load (WIDTH bits)
//   ud          : sequencer -> counter, count direction (1 = up)
//   count_in    : counter -> sequencer, current count (WIDTH bits)
//   rollover_in : counter -> sequencer, rollover flag
// Modports: master = sequencer side, slave = counter side.
// ----------------------------------------------------------------------------
interface counter_ud_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             load_en;
    logic [WIDTH-1:0] load;
    logic             ud;
    logic [WIDTH-1:0] count_in;
    logic             rollover_in;

    modport master (
        output load_en,
        output load,
        output ud,
        input  count_in,
        input  rollover_in
    );

    modport slave (
        input  load_en,
        input  load,
        input  ud,
        output count_in,
        output rollover_in
    );
endinterface

// File: rtl/counter_ud_ctrl.sv
// ----------------------------------------------------------------------------
// counter_ud_ctrl
// Sweep sequencer for the up/down counter. Loads a lower limit, counts up to
// an upper limit, then either finishes (one-shot) or bounces between limits.
// While idle it holds the counter by reloading the value it currently holds,
// because the counter has no enable.
//
// Ports:
//   clk, rstn            : clock (rising edge), synchronous active-low reset
//   start, stop, bounce  : sweep control (stop beats start)
//   lo_lim, hi_lim       : sweep limits, sampled on an accepted start
//   cnt (master)         : load_en/load/ud to counter, count_in/rollover_in back
//   busy                 : sweep in progress (LOAD, UP or DOWN)
//   done                 : one-cycle pulse at the end of a one-shot sweep
//   cfg_err              : one-cycle pulse when a start has lo_lim >= hi_lim
//   sweeps               : DOWN->UP turnarounds, saturating at 255
//   mismatch             : sticky feedback error
//
// Optional feature: define CUD_CTRL_CHECK_EN to compare the counter feedback
// against the tracked value every cycle; otherwise mismatch is tied low and
// the feedback ports are unused.
// ----------------------------------------------------------------------------
module counter_ud_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic              bounce,
    input  logic [WIDTH-1:0]  lo_lim,
    input  logic [WIDTH-1:0]  hi_lim,
    counter_ud_ctrl_if.master cnt,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [7:0]        sweeps,
    output logic              mismatch
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] exp_r;       // value the counter holds this cycle
    logic [WIDTH-1:0] exp_nx_s;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] lo_nx_s;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] hi_nx_s;
    logic             bounce_r;
    logic             bounce_nx_s;
    logic [7:0]       sweeps_nx_s;
    logic             accept_s;
    logic             cfg_err_nx_s;
    logic [WIDTH-1:0] exp_inc_s;
    logic [WIDTH-1:0] exp_dec_s;
    logic             load_en_nx_s;
    logic [WIDTH-1:0] load_nx_s;
    logic             ud_nx_s;
    logic             busy_nx_s;
    logic             done_nx_s;
    logic             mismatch_nx_s;

    assign exp_inc_s = exp_r + WIDTH'(1);
    assign exp_dec_s = exp_r - WIDTH'(1);

    // Next state and next internal registers; an abort still performs the
    // current state's counter action, only the transition is replaced.
    always_comb begin
        state_nx_s   = state_r;
        exp_nx_s     = exp_r;
        lo_nx_s      = lo_r;
        hi_nx_s      = hi_r;
        bounce_nx_s  = bounce_r;
        sweeps_nx_s  = sweeps;
        accept_s     = 1'b0;
        cfg_err_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (lo_lim < hi_lim) begin
                        accept_s    = 1'b1;
                        state_nx_s  = ST_LOAD;
                        lo_nx_s     = lo_lim;
                        hi_nx_s     = hi_lim;
                        bounce_nx_s = bounce;
                        sweeps_nx_s = 8'd0;
                    end else begin
                        cfg_err_nx_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                exp_nx_s = lo_r;
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_UP;
                end
            end
            ST_UP: begin
                exp_nx_s = exp_inc_s;
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (exp_inc_s == hi_r) begin
                    if (bounce_r) begin
                        state_nx_s = ST_DOWN;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = ST_UP;
                end
            end
            ST_DOWN: begin
                exp_nx_s = exp_dec_s;
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (exp_dec_s == lo_r) begin
                    state_nx_s = ST_UP;
                    if (sweeps != 8'hFF) begin
                        sweeps_nx_s = sweeps + 8'd1;
                    end else begin
                        sweeps_nx_s = sweeps;
                    end
                end else begin
                    state_nx_s = ST_DOWN;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Moore output decode of the next state so the outputs can be registered.
    always_comb begin
        load_en_nx_s = 1'b1;
        load_nx_s    = exp_nx_s;
        ud_nx_s      = 1'b1;
        busy_nx_s    = 1'b0;
        done_nx_s    = 1'b0;
        case (state_nx_s)
            ST_IDLE: begin
                load_en_nx_s = 1'b1;
            end
            ST_LOAD: begin
                load_nx_s = lo_nx_s;
                busy_nx_s = 1'b1;
            end
            ST_UP: begin
                load_en_nx_s = 1'b0;
                busy_nx_s    = 1'b1;
            end
            ST_DOWN: begin
                load_en_nx_s = 1'b0;
                ud_nx_s      = 1'b0;
                busy_nx_s    = 1'b1;
            end
            ST_DONE: begin
                done_nx_s = 1'b1;
            end
            default: begin
                load_en_nx_s = 1'b1;
            end
        endcase
    end

`ifdef CUD_CTRL_CHECK_EN
    logic fb_err_s;

    assign fb_err_s = (cnt.count_in != exp_r) || (cnt.rollover_in != (&exp_r));

    // Sticky feedback error; an accepted start re-arms the checker.
    always_comb begin
        if (accept_s) begin
            mismatch_nx_s = 1'b0;
        end else if (fb_err_s) begin
            mismatch_nx_s = 1'b1;
        end else begin
            mismatch_nx_s = mismatch;
        end
    end
`else
    logic unused_feedback_s;

    assign unused_feedback_s = ^{cnt.count_in, cnt.rollover_in};
    assign mismatch_nx_s     = 1'b0;
`endif

    // State, internal registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            exp_r       <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            bounce_r    <= 1'b0;
            sweeps      <= 8'd0;
            mismatch    <= 1'b0;
            cnt.load_en <= 1'b1;
            cnt.load    <= {WIDTH{1'b0}};
            cnt.ud      <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            exp_r       <= exp_nx_s;
            lo_r        <= lo_nx_s;
            hi_r        <= hi_nx_s;
            bounce_r    <= bounce_nx_s;
            sweeps      <= sweeps_nx_s;
            mismatch    <= mismatch_nx_s;
            cnt.load_en <= load_en_nx_s;
            cnt.load    <= load_nx_s;
            cnt.ud      <= ud_nx_s;
            busy        <= busy_nx_s;
            done        <= done_nx_s;
            cfg_err     <= cfg_err_nx_s;
        end
    end

endmodule
